// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module : div_unit_pkg
// Brief  : Shared types and constants for the iterative RV32M divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int XLEN = 32;

    typedef logic signed [XLEN-1:0] signed_word;

    localparam logic [XLEN-1:0] C_WORD_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_WORD_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_PREP = 2'd1,
        DS_ITER = 2'd2,
        DS_SIGN = 2'd3
    } div_state_t;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
// Module : div_unit_if
// Brief  : Issue/complete handshake between the execute stage and the divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface div_unit_if;
    import div_unit_pkg::*;

    logic       start;
    div_op_t    op;
    signed_word src1;
    signed_word src2;
    logic       flush;
    logic       busy;
    logic       done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, src1, src2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src1, src2, flush,
        output busy, done, result
    );

endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module : div_unit
// Brief  : Radix-2 restoring divider for DIV/DIVU/REM/REMU, one bit per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = div_unit_pkg::XLEN
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    div_unit_if.slave   bus
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = DS_IDLE;
    localparam logic [1:0] ST_PREP = DS_PREP;
    localparam logic [1:0] ST_ITER = DS_ITER;
    localparam logic [1:0] ST_SIGN = DS_SIGN;

    logic [1:0]      r_state;
    div_op_t         r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_ovf;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_signed  = ~r_op[0];
    assign w_ovf     = w_signed && (r_a == C_WORD_MIN) && (r_b == C_WORD_ONES);
    // Partial remainder is one bit wider than the word so the trial borrow is visible.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_trial   = w_shift - {1'b0, r_div};
    assign w_quo_fix = r_qneg ? -r_quo : r_quo;
    assign w_rem_fix = r_rneg ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.src1;
                        r_b     <= bus.src2;
                        r_busy  <= 1'b1;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    // Special cases clear both sign flags so SIGN passes them through untouched.
                    if (r_b == '0) begin
                        r_quo   <= C_WORD_ONES;
                        r_rem   <= r_a;
                        r_qneg  <= 1'b0;
                        r_rneg  <= 1'b0;
                        r_state <= ST_SIGN;
                    end else if (w_ovf) begin
                        r_quo   <= C_WORD_MIN;
                        r_rem   <= '0;
                        r_qneg  <= 1'b0;
                        r_rneg  <= 1'b0;
                        r_state <= ST_SIGN;
                    end else begin
                        r_quo   <= mag(r_a, w_signed);
                        r_div   <= mag(r_b, w_signed);
                        r_rem   <= '0;
                        r_qneg  <= w_signed & (r_a[XLEN-1] ^ r_b[XLEN-1]);
                        r_rneg  <= w_signed & r_a[XLEN-1];
                        r_cnt   <= '0;
                        r_state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
                    r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module : tb_div_unit
// Brief  : Directed and randomised self-checking bench for div_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_unit_if bus();

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] prev = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src1  = a;
        bus.src2  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input div_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        int k;
        issue(op, a, b);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
        wait_done(k);
        chk({tag, "_lat"}, 32'(k + 1), 32'(lat));
        chk({tag, "_res"}, bus.result, exp);
        chk({tag, "_busy_lo"}, {31'b0, bus.busy}, 32'd0);
        prev = exp;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    initial begin
        int          k;
        int          f;
        int          lat;
        int          sel;
        div_op_t     rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] exp;

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = DIV_OP_DIV;
        bus.src1  = '0;
        bus.src2  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'b0, bus.busy}, 32'd0);
        chk("rst_done",   {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("div_100_7",   DIV_OP_DIV,  32'd100,         32'd7,           32'd14,          35);
        run("rem_100_7",   DIV_OP_REM,  32'd100,         32'd7,           32'd2,           35);
        run("rem_m7_2",    DIV_OP_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   35);
        run("div_m7_2",    DIV_OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   35);
        run("div_7_m2",    DIV_OP_DIV,  32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   35);
        run("rem_7_m2",    DIV_OP_REM,  32'd7,           32'hFFFF_FFFE,   32'd1,           35);
        run("divu_max_2",  DIV_OP_DIVU, 32'hFFFF_FFFF,   32'd2,           32'h7FFF_FFFF,   35);
        run("remu_max_16", DIV_OP_REMU, 32'hFFFF_FFFF,   32'h10,          32'hF,           35);
        run("divu_min_m1", DIV_OP_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           35);
        run("remu_min_m1", DIV_OP_REMU, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   35);
        run("div_5_0",     DIV_OP_DIV,  32'd5,           32'd0,           32'hFFFF_FFFF,   3);
        run("remu_5_0",    DIV_OP_REMU, 32'd5,           32'd0,           32'd5,           3);
        run("div_ovf",     DIV_OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   3);
        run("rem_ovf",     DIV_OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           3);

        // Flush at edge t+10, restart sampled at edge t+12.
        issue(DIV_OP_DIV, 32'd100, 32'd7);
        sel = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (bus.done) sel++;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy",   {31'b0, bus.busy}, 32'd0);
        chk("flush_done",   {31'b0, bus.done}, 32'd0);
        chk("flush_result", bus.result, prev);
        @(posedge clk);
        #1;
        if (bus.done) sel++;
        chk("flush_no_done", 32'(sel), 32'd0);
        run("after_flush", DIV_OP_DIV, 32'd100, 32'd7, 32'd14, 35);

        // A second start while busy must be ignored.
        issue(DIV_OP_DIV, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = DIV_OP_REMU;
        bus.src1  = 32'd9;
        bus.src2  = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(k);
        chk("ign_lat", 32'(k), 32'd29);
        chk("ign_res", bus.result, 32'd14);
        prev = 32'd14;

        issue(DIV_OP_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy",   {31'b0, bus.busy}, 32'd0);
        chk("midrst_done",   {31'b0, bus.done}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        prev = 32'd0;

        for (int n = 0; n < 500; n++) begin
            rop = div_op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) rb = ~32'($urandom_range(0, 15));
            lat = ((rb == 32'd0) || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 2 : 34;
            f   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 40) : 0;
            exp = model(rop, ra, rb);
            issue(rop, ra, rb);
            k = -1;
            for (int i = 1; i <= 40; i++) begin
                if (i == f) bus.flush = 1'b1;
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
                if (bus.done) begin
                    k = i;
                    break;
                end
            end
            if (f != 0 && f <= lat) begin
                chk("rnd_flush_no_done", 32'(k), 32'hFFFF_FFFF);
                chk("rnd_flush_result",  bus.result, prev);
            end else begin
                chk("rnd_lat", 32'(k), 32'(lat));
                chk("rnd_res", bus.result, exp);
                prev = exp;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider that sits beside the combinational `alu` in the execute stage and implements DIV, DIVU, REM and REMU. The execute stage issues an operation with a one-cycle `start` pulse and stalls while `busy` is high. The unit returns the result with a one-cycle `done` pulse. Division uses a radix-2 restoring algorithm, one quotient bit per cycle. Divide-by-zero and signed overflow take a short path.

## Interface
- `XLEN`, default 32: operand and result width; must equal `rv32::XLEN`.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  `div_op_t` (2)  DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11.
- `src1`  in  XLEN  dividend, `rv32::signed_word`.
- `src2`  in  XLEN  divisor, `rv32::signed_word`.
- `flush`  in  1  pipeline kill; aborts any operation in flight.
- `busy`  out  1  high from the edge that accepts `start` until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  quotient or remainder; held until the next completion.

## Operation
- Reset (`rst_n`=0 at an edge) forces: state=IDLE, `busy`=0, `done`=0, `result`=0, iteration counter=0.
- States and transitions:
  - IDLE: when `start`=1, latch `op`, `src1` and `src2`, set `busy`=1 and go to PREP.
  - PREP: detect the special cases.
    - Divisor zero: go to SIGN with quotient=all ones and remainder=dividend, for every op.
    - Signed overflow (DIV/REM with `src1`=0x8000_0000 and `src2`=0xFFFF_FFFF): go to SIGN with quotient=0x8000_0000 and remainder=0.
    - Otherwise: load magnitudes (absolute values for signed ops, raw values for unsigned ops), record the quotient sign (src1[31]^src2[31]) and remainder sign (src1[31]), clear the counter, and go to ITER.
  - ITER: each cycle, shift the {rem, quo} pair left by one. Trial-subtract the divisor from the 33-bit partial remainder. If the result is non-negative, commit it and set quo[0]. After 32 iterations (counter 0..31) go to SIGN.
  - SIGN: apply sign correction for signed ops on the normal path only.
    - Negate the quotient if the quotient sign is set.
    - Negate the remainder if the remainder sign is set.
    - Load `result` with the quotient (DIV/DIVU) or the remainder (REM/REMU).
    - Set `done`=1 and `busy`=0, and go to IDLE.
- Result rules match the RISC-V spec: division truncates toward zero, and the remainder takes the sign of the dividend.
- `start` while `busy`=1 is ignored, with no error indication.
- `flush`=1 at any edge forces state=IDLE, `busy`=0 and `done`=0.
  - `result` keeps its old value.
  - flush has priority over `start` at the same edge, so that request is dropped.
  - flush has priority over completion, so no `done` pulse is produced.
- Reset has priority over flush and over every other event.

## Timing
- Let `start` be sampled at edge t.
- Normal path: PREP at t+1, ITER at edges t+2..t+33, SIGN at edge t+34. `done` is high during the cycle following edge t+34. Latency is 35 edges from start to the edge where the consumer samples `done`.
- Special path: PREP at t+1, SIGN at t+2. `done` is sampled at edge t+3.
- `busy` is high from after edge t to edge t+34 (or t+2) and falls in the same edge that raises `done`.
- Back-to-back operation: a `start` presented during the `done` cycle is accepted, because the unit is already in IDLE.
- No combinational paths from inputs to outputs.

## Structure
- Add `div_op_t` (2-bit enum) and the state enum `div_state_t` (IDLE, PREP, ITER, SIGN) to the `lexington` package.
- Add the overflow constants (0x8000_0000, all ones) to the `rv32` package if they are not already there.
- Single module with no sub-modules. The 33-bit trial subtractor is inline.

## Test plan
- DIV 100/7: result=14, `done` sampled 35 edges after start. REM 100/7: result=2. REM -7/2 (0xFFFF_FFF9, 2): result=0xFFFF_FFFF. DIV -7/2: result=0xFFFF_FFFD.
- DIVU 0xFFFF_FFFF/2: result=0x7FFF_FFFF. REMU 0xFFFF_FFFF/0x10: result=0xF.
- DIV 5/0: result=0xFFFF_FFFF. REMU 5/0: result=5. DIV 0x8000_0000/-1: result=0x8000_0000. REM of the same operands: result=0. All four complete with 3-edge latency.
- Start DIV 100/7, pulse `flush` at edge t+10: `busy` falls, no `done` pulse appears, and `result` keeps its previous value. A new start at t+12 completes normally.
- Assert `start` with different operands at t+5 while busy: ignored, and the original result is returned.
- Deassert `rst_n` mid-ITER: all outputs return to 0. Then run 500 random ops (including random flushes) against a behavioural model and require zero mismatches.
